hc595_driver: RTL



---
 rtl/hc595_driver.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hc595_driver.sv
// hc595_driver: writer for a 74HC595 chain. It accepts a word on Valid/Ready, shifts it out on Ser/Srclk, then pulses Rclk.
// A transfer takes 2*DIV*WIDTH+2*DIV cycles and Valid is ignored while Busy. Defining HC595_CLR_EN adds the Clr/Srclr_N clear path.
module hc595_driver #(
  parameter int WIDTH     = 16,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Data,
  input  logic             Valid,
`ifdef HC595_CLR_EN
  input  logic             Clr,
  output logic             Srclr_N,
`endif
  output logic             Ready,
  output logic             Ser,
  output logic             Srclk,
  output logic             Rclk,
  output logic             Busy
);

  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SLO   = 3'd1;
  localparam logic [2:0] S_SHI   = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
`ifdef HC595_CLR_EN
  localparam logic [2:0] S_CLR   = 3'd5;
`endif

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_q, ser_d;
  logic             srclk_q, srclk_d;
  logic             rclk_q, rclk_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             phase_end;
  logic             cur_bit;
`ifdef HC595_CLR_EN
  logic             srclr_n_q, srclr_n_d;
`endif

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    phase_end = (cnt_q == CNT_LAST);
    cnt_d     = (state_q == S_IDLE || phase_end) ? '0 : cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
`ifdef HC595_CLR_EN
        if (Clr) begin
          state_d = S_CLR;
        end else
`endif
        if (Valid) begin
          state_d  = S_SLO;
          shreg_d  = Data;
          bitcnt_d = BCW'(WIDTH);
        end
      end
      S_SLO: begin
        if (phase_end) state_d = S_SHI;
      end
      S_SHI: begin
        if (phase_end) begin
          shreg_d  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          bitcnt_d = bitcnt_q - BCW'(1);
          state_d  = (bitcnt_q == BCW'(1)) ? S_LATCH : S_SLO;
        end
      end
      S_LATCH: begin
        if (phase_end) state_d = S_GAP;
      end
      S_GAP: begin
        if (phase_end) state_d = S_IDLE;
      end
`ifdef HC595_CLR_EN
      S_CLR: begin
        if (phase_end) state_d = S_LATCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    cur_bit = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
    case (state_d)
      S_SLO:          ser_d = cur_bit;
      S_SHI, S_LATCH: ser_d = ser_q;
      default:        ser_d = 1'b0;
    endcase
    srclk_d = (state_d == S_SHI);
    rclk_d  = (state_d == S_LATCH);
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
`ifdef HC595_CLR_EN
    srclr_n_d = (state_d != S_CLR);
`endif
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      ser_q    <= 1'b0;
      srclk_q  <= 1'b0;
      rclk_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
`ifdef HC595_CLR_EN
      srclr_n_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      ser_q    <= ser_d;
      srclk_q  <= srclk_d;
      rclk_q   <= rclk_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
`ifdef HC595_CLR_EN
      srclr_n_q <= srclr_n_d;
`endif
    end
  end

  assign Ready = ready_q;
  assign Busy  = busy_q;
  assign Ser   = ser_q;
  assign Srclk = srclk_q;
  assign Rclk  = rclk_q;
`ifdef HC595_CLR_EN
  assign Srclr_N = srclr_n_q;
`endif

endmodule
